axis_in_stream_if_v2: RTL and testbench



---
 rtl/axis_in_stream_if_v2.sv | 125 ++++++++++++
 tb/tb_axis_in_stream_if_v2.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/axis_in_stream_if_v2.sv
// axis_in_stream_if_v2: AXIS beat buffer downsized into sparse-strobe isif lanes with occupancy and frame status
module axis_in_stream_if_v2 #(
  parameter int TBITS = 64,
  parameter int TBYTE = 8,
  parameter int OBITS = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     TVALID,
  output logic                     TREADY,
  input  logic [TBITS-1:0]         TDATA,
  input  logic [TBYTE-1:0]         TKEEP,
  input  logic                     TLAST,
  input  logic                     TUSER,
  output logic [OBITS-1:0]         isif_data_dout,
  output logic [OBITS/8-1:0]       isif_strb_dout,
  output logic                     isif_last_dout,
  output logic                     isif_user_dout,
  output logic                     isif_empty_n,
  input  logic                     isif_read,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [15:0]              frame_cnt
);
  localparam int OBYTE = OBITS / 8;
  localparam int RATIO = TBITS / OBITS;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = RATIO > 1 ? $clog2(RATIO) : 1;
  localparam int BW = TBITS + TBYTE + 2;
  typedef enum logic [1:0] {HOLD_EMPTY, LOAD, EMIT} state_t;
  state_t r_state, w_nstate;
  logic [BW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0] r_occ, w_occ_nxt;
  logic r_tready, r_init;
  logic [15:0] r_frame_cnt;
  logic [TBITS-1:0] r_h_data;
  logic [TBYTE-1:0] r_h_keep;
  logic r_h_last, r_h_user;
  logic [LW-1:0] r_lane, w_nxt_lane, w_hfirst;
  logic w_nxt_found, w_wr, w_pop, w_want, w_drop, w_avail, w_emit;
  logic [TBITS-1:0] w_head_data;
  logic [TBYTE-1:0] w_head_keep;
  logic w_head_last, w_head_user;
  logic [OBITS-1:0] w_ldata [RATIO];
  logic [OBYTE-1:0] w_lkeep [RATIO];
  logic [RATIO-1:0] w_lnz, w_hnz;

  for (genvar g = 0; g < RATIO; g++) begin : g_lane
    assign w_ldata[g] = r_h_data[g*OBITS +: OBITS];
    assign w_lkeep[g] = r_h_keep[g*OBYTE +: OBYTE];
    assign w_lnz[g]   = |w_lkeep[g];
    assign w_hnz[g]   = |w_head_keep[g*OBYTE +: OBYTE];
  end

  assign {w_head_user, w_head_last, w_head_keep, w_head_data} = r_mem[r_rptr];
  assign w_wr      = TVALID && r_tready;
  assign w_avail   = r_occ != '0;
  assign w_drop    = ~|w_hnz && !w_head_last;
  assign w_emit    = r_state == EMIT;
  assign w_occ_nxt = r_occ + (AW+1)'(w_wr) - (AW+1)'(w_pop);

  always_comb begin
    w_nxt_found = 1'b0;
    w_nxt_lane  = '0;
    w_hfirst    = '0;
    for (int j = RATIO - 1; j >= 0; j--) begin
      if (w_lnz[j] && j > int'(r_lane)) begin
        w_nxt_found = 1'b1;
        w_nxt_lane  = LW'(j);
      end
      if (w_hnz[j]) w_hfirst = LW'(j);
    end
  end

  always_comb begin
    w_want   = r_state == LOAD || (w_emit && isif_read && !w_nxt_found);
    w_pop    = w_want && w_avail;
    w_nstate = r_state == HOLD_EMPTY ? (w_avail ? LOAD : HOLD_EMPTY) :
               !w_want ? r_state : !w_avail ? HOLD_EMPTY : w_drop ? LOAD : EMIT;
  end

  always_ff @(posedge clk) if (w_wr) r_mem[r_wptr] <= {TUSER, TLAST, TKEEP, TDATA};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= HOLD_EMPTY;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_occ       <= '0;
      r_tready    <= 1'b0;
      r_init      <= 1'b0;
      r_frame_cnt <= '0;
      r_h_data    <= '0;
      r_h_keep    <= '0;
      r_h_last    <= 1'b0;
      r_h_user    <= 1'b0;
      r_lane      <= '0;
    end else begin
      r_state     <= w_nstate;
      r_init      <= 1'b1;
      r_tready    <= r_init && w_occ_nxt != (AW+1)'(DEPTH);
      r_occ       <= w_occ_nxt;
      r_frame_cnt <= r_frame_cnt + 16'(w_wr && TLAST);
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_pop && !w_drop) begin
        r_h_data <= w_head_data;
        r_h_keep <= w_head_keep;
        r_h_last <= w_head_last;
        r_h_user <= w_head_user;
        r_lane   <= w_hfirst;
      end else if (w_emit && isif_read && w_nxt_found) r_lane <= w_nxt_lane;
    end
  end

  assign TREADY         = r_tready;
  assign occupancy      = r_occ;
  assign frame_cnt      = r_frame_cnt;
  assign isif_empty_n   = w_emit;
  assign isif_data_dout = w_emit && |w_lnz ? w_ldata[r_lane] : '0;
  assign isif_strb_dout = w_emit ? w_lkeep[r_lane] : '0;
  assign isif_last_dout = w_emit && r_h_last && !w_nxt_found;
  assign isif_user_dout = w_emit && r_h_user;
endmodule

// File: tb/tb_axis_in_stream_if_v2.sv
// tb_axis_in_stream_if_v2: directed bench with a lane-queue model checked every cycle
module tb_axis_in_stream_if_v2;
  logic clk = 1'b0;
  logic rst, TVALID, TREADY, TLAST, TUSER;
  logic [63:0] TDATA;
  logic [7:0] TKEEP;
  logic [15:0] isif_data_dout;
  logic [1:0] isif_strb_dout;
  logic isif_last_dout, isif_user_dout, isif_empty_n, isif_read;
  logic [2:0] occupancy;
  logic [15:0] frame_cnt;

  axis_in_stream_if_v2 #(.TBITS(64), .TBYTE(8), .OBITS(16), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .TVALID(TVALID), .TREADY(TREADY), .TDATA(TDATA), .TKEEP(TKEEP),
    .TLAST(TLAST), .TUSER(TUSER), .isif_data_dout(isif_data_dout), .isif_strb_dout(isif_strb_dout),
    .isif_last_dout(isif_last_dout), .isif_user_dout(isif_user_dout), .isif_empty_n(isif_empty_n),
    .isif_read(isif_read), .occupancy(occupancy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [15:0] d; logic [1:0] s; logic l; logic u;} lane_t;
  lane_t q[$];
  int checks = 0, failures = 0, m_frames = 0;
  int acc, idx, nl, gaps, extra, n;
  logic hs, prev;
  logic [15:0] first_d, last_d;

  function automatic logic [63:0] bd(input int k);
    logic [63:0] r;
    for (int j = 0; j < 4; j++) r[16*j +: 16] = 16'(32'hA000 + k * 4 + j);
    return r;
  endfunction

  function automatic void push_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
    int hi;
    lane_t ln;
    hi = -1;
    for (int i = 0; i < 4; i++) if (k[2*i +: 2] != 2'b00) hi = i;
    if (hi < 0 && l) begin
      ln.d = '0; ln.s = '0; ln.l = 1'b1; ln.u = u;
      q.push_back(ln);
    end
    for (int i = 0; i <= hi; i++) if (k[2*i +: 2] != 2'b00) begin
      ln.d = d[16*i +: 16]; ln.s = k[2*i +: 2]; ln.l = l && i == hi; ln.u = u;
      q.push_back(ln);
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    if (isif_empty_n) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL lane_spurious actual=%h required=no lane", {isif_data_dout, isif_strb_dout, isif_last_dout, isif_user_dout});
      end else if ({isif_data_dout, isif_strb_dout, isif_last_dout, isif_user_dout} != q[0]) begin
        failures++;
        $display("FAIL lane_model actual=%h required=%h", {isif_data_dout, isif_strb_dout, isif_last_dout, isif_user_dout}, q[0]);
      end
    end
    chk("frame_model", 64'(frame_cnt), 64'(m_frames % 65536));
    if (rst) begin
      q.delete();
      m_frames = 0;
    end else begin
      if (isif_read && isif_empty_n && q.size() > 0) void'(q.pop_front());
      if (TVALID && TREADY) begin
        push_beat(TDATA, TKEEP, TLAST, TUSER);
        m_frames += int'(TLAST);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
    logic ok;
    int c;
    TVALID = 1'b1; TDATA = d; TKEEP = k; TLAST = l; TUSER = u; c = 0;
    do begin
      ok = TREADY;
      tick();
      c++;
    end while (!ok && c < 200);
    TVALID = 1'b0;
    chk("send_handshake", 64'(ok), 64'd1);
  endtask

  initial begin
    rst = 1'b1; TVALID = 1'b1; TDATA = 64'h0123_4567_89AB_CDEF; TKEEP = 8'hFF; TLAST = 1'b1; TUSER = 1'b1; isif_read = 1'b0;
    repeat (3) tick();
    chk("reset_tready", 64'(TREADY), 64'd0);
    chk("reset_empty_n", 64'(isif_empty_n), 64'd0);
    chk("reset_frame", 64'(frame_cnt), 64'd0);
    chk("reset_occ", 64'(occupancy), 64'd0);
    chk("reset_isif", 64'({isif_data_dout, isif_strb_dout, isif_last_dout, isif_user_dout}), 64'd0);
    rst = 1'b0; TVALID = 1'b0;
    chk("rel_tready0", 64'(TREADY), 64'd0);
    tick();
    chk("rel_tready1", 64'(TREADY), 64'd0);
    tick();
    chk("rel_tready2", 64'(TREADY), 64'd1);

    isif_read = 1'b1;
    send(64'h4444_3333_2222_1111, 8'hFF, 1'b1, 1'b0);
    chk("lat_edge0", 64'(isif_empty_n), 64'd0);
    tick();
    chk("lat_edge1", 64'(isif_empty_n), 64'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("full_lane%0d", i), 64'({isif_empty_n, isif_data_dout, isif_strb_dout, isif_last_dout}),
          64'({1'b1, 16'(32'h1111 * (i + 1)), 2'b11, 1'(i == 3)}));
      tick();
    end
    chk("full_done", 64'(isif_empty_n), 64'd0);
    chk("full_frame", 64'(frame_cnt), 64'd1);

    send(64'h8888_7777_6666_5555, 8'h3C, 1'b1, 1'b1);
    tick(); tick();
    chk("sparse_lane1", 64'({isif_data_dout, isif_strb_dout, isif_last_dout, isif_user_dout}), 64'({16'h6666, 2'b11, 1'b0, 1'b1}));
    tick();
    chk("sparse_lane2", 64'({isif_data_dout, isif_strb_dout, isif_last_dout, isif_user_dout}), 64'({16'h7777, 2'b11, 1'b1, 1'b1}));
    tick();
    chk("sparse_done", 64'(isif_empty_n), 64'd0);

    send(64'hDEAD_BEEF_0BAD_F00D, 8'h00, 1'b0, 1'b0);
    send(64'h1234_5678_9ABC_DEF0, 8'h00, 1'b1, 1'b1);
    n = 0;
    while (!isif_empty_n && n < 10) begin tick(); n++; end
    chk("zero_lane", 64'({isif_empty_n, isif_data_dout, isif_strb_dout, isif_last_dout, isif_user_dout}), 64'({1'b1, 16'h0, 2'b00, 1'b1, 1'b1}));
    tick();
    extra = 0;
    repeat (4) begin extra += int'(isif_empty_n); tick(); end
    chk("zero_extra", 64'(extra), 64'd0);

    isif_read = 1'b0; acc = 0;
    for (int c = 0; c < 20; c++) begin
      TVALID = acc < 6; TDATA = bd(acc); TKEEP = 8'hFF; TLAST = 1'b0; TUSER = 1'b0;
      hs = TVALID && TREADY;
      tick();
      if (hs) acc++;
    end
    chk("bp_accepted", 64'(acc), 64'd5);
    chk("bp_tready", 64'(TREADY), 64'd0);
    chk("bp_occ", 64'(occupancy), 64'd4);
    chk("bp_held", 64'({isif_empty_n, isif_data_dout}), 64'({1'b1, 16'hA000}));
    isif_read = 1'b1;
    tick();
    isif_read = 1'b0;
    chk("bp_pulse_occ", 64'(occupancy), 64'd4);
    chk("bp_pulse_tready", 64'(TREADY), 64'd0);
    chk("bp_pulse_lane", 64'(isif_data_dout), 64'hA001);
    tick();
    chk("bp_occ_hold", 64'(occupancy), 64'd4);
    isif_read = 1'b1;
    repeat (3) tick();
    chk("bp_occ_after", 64'(occupancy), 64'd3);
    chk("bp_tready_after", 64'(TREADY), 64'd1);
    tick();
    TVALID = 1'b0;
    chk("bp_sixth_occ", 64'(occupancy), 64'd4);
    repeat (40) tick();
    chk("bp_drain_empty", 64'(isif_empty_n), 64'd0);
    chk("bp_drain_occ", 64'(occupancy), 64'd0);

    idx = 0; nl = 0; gaps = 0; prev = 1'b0; first_d = '0; last_d = '0;
    for (int c = 0; c < 60; c++) begin
      TVALID = idx < 8; TDATA = bd(16 + idx); TKEEP = 8'hFF; TLAST = idx == 7; TUSER = 1'b0;
      if (isif_empty_n) begin
        if (nl == 0) first_d = isif_data_dout;
        else if (!prev) gaps++;
        nl++;
        last_d = isif_data_dout;
      end
      prev = isif_empty_n;
      hs = TVALID && TREADY;
      tick();
      if (hs) idx++;
    end
    TVALID = 1'b0;
    chk("b2b_beats", 64'(idx), 64'd8);
    chk("b2b_lanes", 64'(nl), 64'd32);
    chk("b2b_gaps", 64'(gaps), 64'd0);
    chk("b2b_first", 64'(first_d), 64'hA040);
    chk("b2b_last", 64'(last_d), 64'hA05F);

    isif_read = 1'b0;
    send(bd(30), 8'hFF, 1'b0, 1'b0);
    send(bd(31), 8'hFF, 1'b0, 1'b0);
    send(bd(32), 8'hFF, 1'b0, 1'b0);
    repeat (3) tick();
    chk("mid_occ", 64'(occupancy), 64'd2);
    chk("mid_held", 64'(isif_empty_n), 64'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_occ", 64'(occupancy), 64'd0);
    chk("mid_rst_tready", 64'(TREADY), 64'd0);
    chk("mid_rst_frame", 64'(frame_cnt), 64'd0);
    chk("mid_rst_isif", 64'({isif_empty_n, isif_data_dout, isif_strb_dout, isif_last_dout, isif_user_dout}), 64'd0);
    tick();
    rst = 1'b0; isif_read = 1'b1;
    extra = 0;
    repeat (10) begin extra += int'(isif_empty_n); tick(); end
    chk("mid_no_stale", 64'(extra), 64'd0);

    TKEEP = 8'h03; TLAST = 1'b1; TUSER = 1'b0; acc = 0;
    for (int c = 0; c < 70000 && acc < 65536; c++) begin
      TVALID = 1'b1; TDATA = 64'(acc);
      hs = TREADY;
      tick();
      if (hs) begin
        acc++;
        if (acc == 65535) chk("wrap_ffff", 64'(frame_cnt), 64'hFFFF);
      end
    end
    TVALID = 1'b0;
    chk("wrap_beats", 64'(acc), 64'd65536);
    chk("wrap_frame", 64'(frame_cnt), 64'd0);
    repeat (8) tick();
    chk("wrap_drained", 64'(isif_empty_n), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
